riscv_lsu: RTL and testbench
============================

// Module: riscv_lsu
// PURPOSE
//  Load/store unit between the pipeline MEM stage and the word-only synchronous data memory.
//  Memory contract: one-cycle registered read; write commits at the edge where mem_write=1.
//  Adds byte/halfword loads with sign/zero extension, and byte/halfword stores via a
//  2-cycle read-modify-write (RMW). Flags misaligned accesses and illegal funct3 values.
// PARAMETERS
//  SUBWORD_STORES  1  1: SB/SH do RMW; 0: SB/SH raise req_error, no write
//  CHECK_ALIGN     1  1: misaligned H/W access raises req_error; 0: low address bits ignored
// PORTS
//  clk          in   1   system clock; all state updates on posedge
//  rst          in   1   reset, synchronous, active-high
//  req_valid    in   1   access request this cycle
//  req_ready    out  1   request accepted when req_valid & req_ready
//  req_write    in   1   1=store, 0=load
//  req_funct3   in   3   RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data; low byte/half used for SB/SH
//  load_valid   out  1   load_data valid (one-cycle pulse)
//  load_data    out  32  extended load result
//  req_error    out  1   one-cycle pulse, cycle after a rejected request
//  mem_addr     out  32  to memory: {addr[31:2],2'b00}
//  mem_write    out  1   to memory write enable
//  mem_wdata    out  32  to memory write data
//  mem_rdata    in   32  from memory; valid one cycle after mem_addr
// BEHAVIOUR
//  - States: IDLE, LD_RESP, ST_MERGE. Reset: state=IDLE, load_valid=0, load_data=0, req_error=0.
//  - req_ready = (state != ST_MERGE). mem_addr/mem_write/mem_wdata are combinational.
//  - Accept cycle, any legal op: mem_addr from req_addr; offset and funct3 are captured.
//  - SW: mem_write=1, mem_wdata=req_wdata in the accept cycle. Stays in/returns to IDLE.
//  - LB/LH/LW/LBU/LHU: mem_write=0 on accept; next state LD_RESP.
//  - LD_RESP: load_valid=1; load_data = mem_rdata lane selected by captured addr[1:0],
//    sign-extended (B/H) or zero-extended (BU/HU). A new request may be accepted in the same
//    cycle, giving back-to-back loads at 1 per cycle.
//  - SB/SH: accept cycle reads the word (mem_write=0); next state ST_MERGE.
//  - ST_MERGE: mem_addr=captured word address, mem_write=1, mem_wdata = mem_rdata with the
//    addressed lane replaced (byte lane addr[1:0]; half lane addr[1]). Then IDLE; total 2 cycles.
//  - Rejected request (illegal funct3, store funct3>010, misaligned with CHECK_ALIGN,
//    SB/SH with SUBWORD_STORES=0): accepted, no mem_write, no load_valid; req_error=1 next cycle.
//  - Misaligned: H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0.
//  - load_data holds its last value when load_valid=0.
//  - rst in LD_RESP/ST_MERGE: go to IDLE next edge; a pending merge write is never issued.
//  - Store immediately after ST_MERGE to the same word reads the merged value (write already committed).
// STRUCTURE
//  - Shared riscv_pkg: funct3 constants (FUNCT3_LB..FUNCT3_LHU, FUNCT3_SB..FUNCT3_SW).
//  - The state enum is local to this module.
//  - Sub-module riscv_load_extract (combinational): mem_rdata, offset, funct3 -> load_data.
// TESTING
//  1. LW 0x00800004, mem word 0xDEADBEEF -> load_valid next cycle, load_data=0xDEADBEEF.
//  2. LB 0x00800007 on 0x80112233 -> 0xFFFFFF80; LBU same address -> 0x00000080;
//     LH 0x00800006 -> 0xFFFF8011.
//  3. SB 0x00800001, wdata 0xAA, word 0x11223344 -> mem_write one cycle later with
//     0x1122AA44; req_ready=0 in that cycle.
//     SH 0x00800002, wdata 0xBEEF -> 0xBEEF3344.
//  4. Four back-to-back LWs -> four consecutive load_valid pulses, in order, with correct data.
//  5. LW 0x00800002 -> req_error pulse, no load_valid; SW 0x00800001 -> req_error, mem_write never 1.
//     funct3=011 -> req_error.
//  6. SB accepted, rst asserted in ST_MERGE -> mem_write stays 0; all outputs at reset values.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I load/store funct3 encodings and alignment helper.
package riscv_pkg;
  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;
  // Halfword encodings share funct3[1:0]=01 for H, HU and SH.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    return (f3[1:0] == 2'b01 && off[0]) || (f3 == FUNCT3_LW && off != 2'b00);
  endfunction
endpackage

// File: rtl/riscv_load_extract.sv
// riscv_load_extract: selects the addressed lane of a memory word and extends it.
module riscv_load_extract
  import riscv_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = 8'(rdata_i >> {off_i, 3'b000});
    h = 16'(rdata_i >> {off_i[1], 4'b0000});
    data_o = funct3_i == FUNCT3_LB  ? {{24{b[7]}}, b}  :
             funct3_i == FUNCT3_LH  ? {{16{h[15]}}, h} :
             funct3_i == FUNCT3_LBU ? {24'b0, b}       :
             funct3_i == FUNCT3_LHU ? {16'b0, h}       : rdata_i;
  end
endmodule

// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit with sub-word loads and read-modify-write sub-word stores
// on a word-only, one-cycle-latency data memory.
module riscv_lsu
  import riscv_pkg::*;
#(
  parameter bit SUBWORD_STORES = 1'b1,
  parameter bit CHECK_ALIGN    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        req_error,
  output logic [31:0] mem_addr,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, LD_RESP, ST_MERGE} state_t;
  state_t      state_q, state_d;
  logic [29:0] waddr_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic [15:0] wd_q;
  logic        err_q;
  logic [31:0] last_q;
  logic        acc, legal_f3, bad, ok, merge;
  logic [4:0]  sh;
  logic [31:0] ext, lane_mask, lane_data;

  riscv_load_extract u_extract (
    .rdata_i (mem_rdata),
    .off_i   (off_q),
    .funct3_i(f3_q),
    .data_o  (ext)
  );

  assign req_ready = state_q != ST_MERGE;
  assign acc       = req_valid & req_ready;
  assign merge     = state_q == ST_MERGE;
  assign req_error = err_q;

  always_comb begin
    legal_f3 = req_write ? (req_funct3 == FUNCT3_SW ||
                            (SUBWORD_STORES && (req_funct3 == FUNCT3_SB || req_funct3 == FUNCT3_SH)))
                         : (req_funct3 inside {FUNCT3_LB, FUNCT3_LH, FUNCT3_LW, FUNCT3_LBU, FUNCT3_LHU});
    bad      = !legal_f3 || (CHECK_ALIGN && misaligned(req_funct3, req_addr[1:0]));
    ok       = acc & !bad;
    state_d  = !ok ? IDLE : !req_write ? LD_RESP : req_funct3 == FUNCT3_SW ? IDLE : ST_MERGE;
  end

  // Lane merge for the second RMW cycle; the read word arrives on mem_rdata now.
  always_comb begin
    sh         = f3_q == FUNCT3_SB ? {off_q, 3'b000} : {off_q[1], 4'b0000};
    lane_mask  = (f3_q == FUNCT3_SB ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    lane_data  = ({16'b0, wd_q} << sh) & lane_mask;
    mem_addr   = merge ? {waddr_q, 2'b00} : {req_addr[31:2], 2'b00};
    mem_wdata  = merge ? (mem_rdata & ~lane_mask) | lane_data : req_wdata;
    mem_write  = !rst && (merge || (ok && req_write && req_funct3 == FUNCT3_SW));
    load_valid = !rst && state_q == LD_RESP;
    load_data  = load_valid ? ext : last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= acc & bad;
      if (load_valid) last_q <= ext;
      if (acc) begin
        waddr_q <= req_addr[31:2];
        off_q   <= req_addr[1:0];
        f3_q    <= req_funct3;
        wd_q    <= req_wdata[15:0];
      end
    end
  end
endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: directed scoreboard bench for riscv_lsu with a word memory model.
module tb_riscv_lsu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, load_valid, req_error, mem_write;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mem [16] = '{default: 32'h0};
  logic [31:0] lq[$];
  logic [63:0] wq[$];
  int          eq = 0;
  int          total = 0, passed = 0;
  bit          mon_en = 1'b0;

  localparam int NONE = 0, LOAD = 1, WRITE = 2, ERR = 3;

  riscv_lsu dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .load_valid(load_valid), .load_data(load_data),
    .req_error(req_error), .mem_addr(mem_addr), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr[5:2]];
    if (mem_write) mem[mem_addr[5:2]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  always @(negedge clk) if (mon_en) begin
    if (load_valid) begin
      chk("load_pending", 32'(lq.size() > 0), 32'd1);
      if (lq.size() > 0) chk("load_data", load_data, lq.pop_front());
    end
    if (mem_write) begin
      chk("write_pending", 32'(wq.size() > 0), 32'd1);
      if (wq.size() > 0) begin
        logic [63:0] w;
        w = wq.pop_front();
        chk("write_addr", mem_addr, w[63:32]);
        chk("write_data", mem_wdata, w[31:0]);
      end
    end
    if (req_error) begin
      chk("error_pending", 32'(eq > 0), 32'd1);
      if (eq > 0) eq--;
    end
  end

  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int kind,
                       input logic [31:0] ea, input logic [31:0] ed);
    bit r;
    int n;
    if (kind == LOAD) lq.push_back(ed);
    if (kind == WRITE) wq.push_back({ea, ed});
    if (kind == ERR) eq++;
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    n = 0;
    do begin
      @(negedge clk) r = req_ready;
      @(posedge clk);
      n++;
    end while (!r && n < 8);
    if (!r) chk("accept_timeout", 32'(r), 32'd1);
    #1 req_valid = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    @(negedge clk);
    chk({tag, "_load_valid"}, 32'(load_valid), 32'd0);
    chk({tag, "_load_data"}, load_data, 32'd0);
    chk({tag, "_req_error"}, 32'(req_error), 32'd0);
    chk({tag, "_mem_write"}, 32'(mem_write), 32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    step(3);
    rst = 1'b0;
    mon_en = 1'b1;
    reset_checks("reset");
    step(1);
    issue(1, 3'b010, 32'h0080_0004, 32'hDEAD_BEEF, WRITE, 32'h0080_0004, 32'hDEAD_BEEF);
    issue(0, 3'b010, 32'h0080_0004, 0, LOAD, 0, 32'hDEAD_BEEF);
    issue(1, 3'b010, 32'h0080_0004, 32'h8011_2233, WRITE, 32'h0080_0004, 32'h8011_2233);
    issue(0, 3'b000, 32'h0080_0007, 0, LOAD, 0, 32'hFFFF_FF80);
    issue(0, 3'b100, 32'h0080_0007, 0, LOAD, 0, 32'h0000_0080);
    issue(0, 3'b001, 32'h0080_0006, 0, LOAD, 0, 32'hFFFF_8011);
    issue(0, 3'b101, 32'h0080_0006, 0, LOAD, 0, 32'h0000_8011);
    issue(0, 3'b000, 32'h0080_0004, 0, LOAD, 0, 32'h0000_0033);
    issue(1, 3'b010, 32'h0080_0008, 32'h1122_3344, WRITE, 32'h0080_0008, 32'h1122_3344);
    issue(1, 3'b000, 32'h0080_0009, 32'h0000_00AA, WRITE, 32'h0080_0008, 32'h1122_AA44);
    chk("merge_ready_low", 32'(req_ready), 32'd0);
    issue(1, 3'b010, 32'h0080_0008, 32'h1122_3344, WRITE, 32'h0080_0008, 32'h1122_3344);
    issue(1, 3'b001, 32'h0080_000A, 32'h0000_BEEF, WRITE, 32'h0080_0008, 32'hBEEF_3344);
    issue(1, 3'b000, 32'h0080_0008, 32'h0000_0077, WRITE, 32'h0080_0008, 32'hBEEF_3377);
    issue(0, 3'b010, 32'h0080_0008, 0, LOAD, 0, 32'hBEEF_3377);
    for (int i = 0; i < 4; i++)
      issue(1, 3'b010, 32'h0080_000C + 32'(4 * i), 32'hA000_0001 + 32'(i), WRITE,
            32'h0080_000C + 32'(4 * i), 32'hA000_0001 + 32'(i));
    for (int i = 0; i < 4; i++)
      issue(0, 3'b010, 32'h0080_000C + 32'(4 * i), 0, LOAD, 0, 32'hA000_0001 + 32'(i));
    step(2);
    chk("b2b_drained", 32'(lq.size()), 32'd0);
    issue(0, 3'b010, 32'h0080_0002, 0, ERR, 0, 0);
    issue(1, 3'b010, 32'h0080_0001, 32'hFFFF_FFFF, ERR, 0, 0);
    issue(0, 3'b011, 32'h0080_0004, 0, ERR, 0, 0);
    issue(1, 3'b100, 32'h0080_0004, 32'h1234_5678, ERR, 0, 0);
    issue(0, 3'b101, 32'h0080_0005, 0, ERR, 0, 0);
    step(2);
    chk("errors_seen", 32'(eq), 32'd0);
    issue(1, 3'b000, 32'h0080_0008, 32'h0000_0055, NONE, 0, 0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    reset_checks("merge_reset");
    step(1);
    issue(0, 3'b010, 32'h0080_0008, 0, LOAD, 0, 32'hBEEF_3377);
    step(3);
    chk("loads_drained", 32'(lq.size()), 32'd0);
    chk("writes_drained", 32'(wq.size()), 32'd0);
    chk("errors_drained", 32'(eq), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
